skid_buffer_async_rst_n: RTL
============================

Name: skid_buffer_async_rst_n

Overview:
- Two-entry valid/ready register slice (skid buffer) with parameterized data width.
- Breaks the combinational timing path on both data/valid (downstream) and ready (upstream), while still sustaining one transfer per clock.
- Consumer-side counterpart to the enable-gated register: the upstream producer drives valid/data, and this block accepts, holds and forwards words under backpressure.
- Placed between pipeline stages wherever a flow-controlled interface needs a registered boundary.

Parameters:
- WIDTH, 4, data word width in bits (WIDTH >= 1).

Ports:
- clk  input  1  rising-edge clock
- async_rst_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronous to clk by the integrator
- s_valid  input  1  upstream word valid
- s_ready  output  1  block can accept a word this cycle
- s_data  input  WIDTH  upstream word
- m_valid  output  1  downstream word valid
- m_ready  input  1  downstream accepts the word this cycle
- m_data  output  WIDTH  downstream word

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Handshake definitions:
  - in_xfer = s_valid & s_ready
  - out_xfer = m_valid & m_ready
- Storage:
  - main register drives m_data/m_valid.
  - skid register holds one overflow word.
  - All outputs come directly from flops; there is no combinational path from any input to any output.
- Reset, while async_rst_n = 0 and immediately on assertion:
  - state EMPTY, m_valid = 0, s_ready = 1, m_data = 0, skid data = 0.
- States and s_ready / m_valid per state:
  - EMPTY: s_ready = 1, m_valid = 0.
  - BUSY: one word in main; s_ready = 1, m_valid = 1.
  - FULL: main + skid both occupied; s_ready = 0, m_valid = 1.
- Transitions, evaluated at posedge clk:
  - EMPTY:
    - in_xfer -> BUSY, main <= s_data.
    - otherwise stay.
  - BUSY:
    - in_xfer & out_xfer -> BUSY, main <= s_data.
    - in_xfer & !out_xfer -> FULL, skid <= s_data.
    - !in_xfer & out_xfer -> EMPTY.
    - otherwise stay, main held.
  - FULL:
    - out_xfer -> BUSY, main <= skid.
    - otherwise stay.
    - in_xfer is impossible here because s_ready = 0.
- Latency: a word accepted in cycle N is presented on m_data with m_valid = 1 in cycle N+1 when the buffer was EMPTY, or when BUSY with a simultaneous out_xfer.
- Throughput: with m_ready held at 1, one word transfers per cycle indefinitely; s_ready never drops.
- Ordering: strictly FIFO; no word is dropped or duplicated.
- Stability rules:
  - While m_valid = 1 and m_ready = 0, m_data and m_valid do not change.
  - s_ready deasserts only in the cycle after a word is captured into skid.
- Upstream protocol: s_data is ignored when in_xfer = 0. The block does not require upstream to hold s_valid, but any upstream violation does not corrupt stored words.
- m_ready may be asserted while m_valid = 0; this has no effect.
- Reset mid-operation: any stored words are discarded immediately. The first cycle after release behaves exactly as EMPTY.
- State encoding is implementer's choice. Illegal encodings recover to EMPTY on the next clock.

Test Plan:
- Reset:
  - Assert async_rst_n = 0 mid-cycle with the buffer FULL -> m_valid = 0, s_ready = 1, m_data = 0 immediately, before the next clk edge.
- Single word:
  - Drive s_valid = 1, s_data = 4'hA for one cycle with m_ready = 0 -> next cycle m_valid = 1, m_data = 4'hA, s_ready = 1.
  - Then raise m_ready for one cycle -> m_valid = 0.
- Streaming:
  - m_ready = 1, send 16 consecutive words 0..F -> outputs 0..F appear on consecutive cycles with 1-cycle latency.
  - s_ready stays 1 throughout.
- Backpressure fill:
  - m_ready = 0, send 4'h3 then 4'h5 -> s_ready = 0 after the second capture.
  - m_data holds 4'h3 stable.
  - A third s_valid with 4'h7 is not accepted.
- Drain:
  - From FULL (3, 5), raise m_ready for 2 cycles -> outputs 4'h3 then 4'h5.
  - s_ready returns to 1 one cycle after the first out_xfer.
  - Ends EMPTY.
- Random:
  - 10k cycles of random s_valid/m_ready with a scoreboard -> in-order, lossless delivery.
  - m_data stable under stall.
  - No combinational input-to-output path (checked by assertion).

Source files
------------

// File: rtl/skid_buffer_async_rst_n_if.sv
// Valid/ready word channel used on both sides of the skid buffer.
// The master drives valid/data and the slave drives ready.
interface skid_buffer_async_rst_n_if #(
  parameter int WIDTH = 4
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/skid_buffer_async_rst_n.sv
// Two-entry valid/ready register slice.
//
// Both data/valid and ready are registered, so the block still sustains one
// word per clock. The main register feeds the downstream port. The skid
// register catches the one word that arrives while downstream stalls.
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | nothing stored; s_ready=1, m_valid=0
// BUSY  | one word in main; s_ready=1, m_valid=1
// FULL  | main and skid occupied; s_ready=0, m_valid=1
//
// The state is encoded as {s_ready, m_valid}. Both handshake outputs are
// therefore plain flop bits with no decode logic behind them. The unused
// code 2'b00 recovers to EMPTY.
module skid_buffer_async_rst_n #(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      async_rst_n,
  skid_buffer_async_rst_n_if.slave  s,
  skid_buffer_async_rst_n_if.master m
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b10,
    ST_BUSY  = 2'b11,
    ST_FULL  = 2'b01
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;
  logic             in_xfer;
  logic             out_xfer;

  assign s.ready  = state[1];
  assign m.valid  = state[0];
  assign m.data   = main_q;

  assign in_xfer  = s.valid & s.ready;
  assign out_xfer = m.valid & m.ready;

  // State register; reset discards any stored words immediately.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and register load enables.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_nxt = ST_BUSY;
          load_main = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // No word can be accepted here because s_ready is low.
        if (out_xfer) begin
          state_nxt      = ST_BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Main and skid data registers. Main holds its value whenever it is not
  // loaded, which keeps m_data stable under a stall.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : s.data;
      end
      if (load_skid) begin
        skid_q <= s.data;
      end
    end
  end

endmodule
